// File: rtl/rx_i2s.sv
// rx_i2s - I2S capture receiver.
//
// Oversamples an external I2S bus (bclk/lrck/sdata driven by the ADC as bus
// master) in the byte_clk_i domain and deserializes 16, 24 or 32 bit stereo
// samples. Each complete frame is written to the input FIFO write port as
// 2N/8 bytes on consecutive cycles: left sample MSB..LSB, then right sample
// MSB..LSB. This is the same byte order in which tx_i2s consumes bytes.
//
// Ports:
//   reset_i               asynchronous active-high reset
//   byte_clk_i            clock for all logic (>= 4x bclk frequency)
//   enable_i              capture enable, level-sensitive
//   bit_depth_i           00=16, 01=24, 10=DoP (captured as 24), 11=32
//   bclk_i/lrck_i/sdata_i asynchronous I2S bus inputs
//   wr_input_FIFO_afull_i FIFO almost-full, checked when a frame completes
//   wr_input_FIFO_full_i  FIFO full, aborts the rest of an emitting frame
//   wr_input_FIFO_en_o    one-cycle write strobe per byte
//   wr_input_FIFO_data_o  byte to write
//   input_streaming_o     high while frames are being captured (RUN)
//   overrun_o             sticky: a frame or part of a frame was dropped
//   frame_err_o           sticky: a slot ended before N bits arrived

module rx_i2s (
    input  logic       reset_i,
    input  logic       byte_clk_i,
    input  logic       enable_i,
    input  logic [1:0] bit_depth_i,
    input  logic       bclk_i,
    input  logic       lrck_i,
    input  logic       sdata_i,
    input  logic       wr_input_FIFO_afull_i,
    input  logic       wr_input_FIFO_full_i,
    output logic       wr_input_FIFO_en_o,
    output logic [7:0] wr_input_FIFO_data_o,
    output logic       input_streaming_o,
    output logic       overrun_o,
    output logic       frame_err_o
);

    // Bit-depth codes, matching the codebase-wide definitions.
    localparam logic [1:0] BIT_DEPTH_16  = 2'd0;
    localparam logic [1:0] BIT_DEPTH_24  = 2'd1;
    localparam logic [1:0] BIT_DEPTH_DOP = 2'd2;
    localparam logic [1:0] BIT_DEPTH_32  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Synchronizers and edge detection
    logic [1:0]  bclk_sync_r;
    logic [1:0]  lrck_sync_r;
    logic [1:0]  sdata_sync_r;
    logic        bclk_prev_r;
    logic        bclk_rise_s;
    logic        lrck_s;
    logic        sdata_s;

    // Framing and capture state
    state_t      state_r;
    logic [5:0]  depth_r;
    logic [4:0]  bit_idx_r;
    logic        lrck_last_r;
    logic        slot_done_r;
    logic [30:0] shift_r;
    logic [31:0] sample_l_r;
    logic [63:0] emit_r;
    logic [3:0]  emit_cnt_r;

    // Combinational helpers
    logic [5:0]  depth_sel_s;
    logic [31:0] mask_s;
    logic [63:0] frame_s;
    logic [31:0] shift_next_s;
    logic [31:0] sample_next_s;
    logic [5:0]  pos_s;
    logic [4:0]  idx_inc_s;
    logic        in_run_s;
    logic        lrck_change_s;
    logic        left_start_s;
    logic        take_s;
    logic        done_s;
    logic        short_s;

    assign bclk_rise_s   = bclk_sync_r[1] & ~bclk_prev_r;
    assign lrck_s        = lrck_sync_r[1];
    assign sdata_s       = sdata_sync_r[1];
    assign in_run_s      = (state_r == ST_RUN);
    assign lrck_change_s = (lrck_s != lrck_last_r);
    assign left_start_s  = bclk_rise_s & lrck_change_s & lrck_last_r & ~lrck_s;
    assign idx_inc_s     = (bit_idx_r == 5'd31) ? 5'd31 : (bit_idx_r + 5'd1);

    // Position of the bit sampled on this rise within the slot it belongs to.
    // On an lrck-change rise the bit is the LSB end of the slot that is
    // closing (I2S one-bit delay), so a 32-bit word in a 32-bit slot gets its
    // final bit at position 32 on that rise even though bit_idx tops out at 31.
    assign pos_s         = {1'b0, bit_idx_r} + 6'd1;
    assign shift_next_s  = {shift_r, sdata_s};
    assign sample_next_s = shift_next_s & mask_s;

    // slot_done_r keeps a saturated bit_idx from completing a slot twice.
    assign take_s  = bclk_rise_s & in_run_s & ~slot_done_r & (pos_s <= depth_r);
    assign done_s  = take_s & (pos_s == depth_r);
    assign short_s = bclk_rise_s & in_run_s & lrck_change_s & ~slot_done_r & (pos_s < depth_r);

    // Decode the requested sample width; DoP travels as 24-bit words.
    always_comb begin
        depth_sel_s = 6'd16;
        case (bit_depth_i)
            BIT_DEPTH_16:  depth_sel_s = 6'd16;
            BIT_DEPTH_24:  depth_sel_s = 6'd24;
            BIT_DEPTH_DOP: depth_sel_s = 6'd24;
            BIT_DEPTH_32:  depth_sel_s = 6'd32;
            default:       depth_sel_s = 6'd16;
        endcase
    end

    // Sample mask and MSB-aligned byte image of the frame for the latched width.
    always_comb begin
        mask_s  = 32'hFFFF_FFFF;
        frame_s = {sample_l_r, sample_next_s};
        case (depth_r)
            6'd16: begin
                mask_s  = 32'h0000_FFFF;
                frame_s = {sample_l_r[15:0], sample_next_s[15:0], 32'h0000_0000};
            end
            6'd24: begin
                mask_s  = 32'h00FF_FFFF;
                frame_s = {sample_l_r[23:0], sample_next_s[23:0], 16'h0000};
            end
            default: begin
                mask_s  = 32'hFFFF_FFFF;
                frame_s = {sample_l_r, sample_next_s};
            end
        endcase
    end

    // Two-flop synchronizers for the bus pins plus bclk history for edge detect.
    always_ff @(posedge byte_clk_i or posedge reset_i) begin
        if (reset_i) begin
            bclk_sync_r  <= 2'b00;
            lrck_sync_r  <= 2'b00;
            sdata_sync_r <= 2'b00;
            bclk_prev_r  <= 1'b0;
        end else begin
            bclk_sync_r  <= {bclk_sync_r[0], bclk_i};
            lrck_sync_r  <= {lrck_sync_r[0], lrck_i};
            sdata_sync_r <= {sdata_sync_r[0], sdata_i};
            bclk_prev_r  <= bclk_sync_r[1];
        end
    end

    // Control FSM, slot framing, sample capture and byte emission.
    always_ff @(posedge byte_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r              <= ST_IDLE;
            depth_r              <= 6'd16;
            bit_idx_r            <= 5'd0;
            lrck_last_r          <= 1'b0;
            slot_done_r          <= 1'b0;
            shift_r              <= 31'd0;
            sample_l_r           <= 32'd0;
            emit_r               <= 64'd0;
            emit_cnt_r           <= 4'd0;
            wr_input_FIFO_en_o   <= 1'b0;
            wr_input_FIFO_data_o <= 8'd0;
            input_streaming_o    <= 1'b0;
            overrun_o            <= 1'b0;
            frame_err_o          <= 1'b0;
        end else begin
            // State transitions; flags clear when capture is (re)armed.
            if (!enable_i) begin
                state_r           <= ST_IDLE;
                input_streaming_o <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r           <= ST_SYNC;
                        input_streaming_o <= 1'b0;
                        overrun_o         <= 1'b0;
                        frame_err_o       <= 1'b0;
                    end
                    ST_SYNC: begin
                        if (left_start_s) begin
                            state_r           <= ST_RUN;
                            depth_r           <= depth_sel_s;
                            input_streaming_o <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (short_s) begin
                            state_r           <= ST_SYNC;
                            input_streaming_o <= 1'b0;
                            frame_err_o       <= 1'b1;
                        end
                    end
                    default: begin
                        state_r           <= ST_IDLE;
                        input_streaming_o <= 1'b0;
                    end
                endcase
            end

            // Slot tracking runs on every detected bclk rise.
            if (bclk_rise_s) begin
                if (take_s) begin
                    shift_r <= shift_next_s[30:0];
                end
                if (done_s) begin
                    slot_done_r <= 1'b1;
                end
                if (lrck_change_s) begin
                    bit_idx_r   <= 5'd0;
                    lrck_last_r <= lrck_s;
                    slot_done_r <= 1'b0;
                end else begin
                    bit_idx_r   <= idx_inc_s;
                end
            end

            if (done_s && !lrck_last_r) begin
                sample_l_r <= sample_next_s;
            end

            // Byte emission; a full FIFO abandons the rest of the frame.
            if (emit_cnt_r != 4'd0) begin
                if (wr_input_FIFO_full_i) begin
                    emit_cnt_r         <= 4'd0;
                    wr_input_FIFO_en_o <= 1'b0;
                    overrun_o          <= 1'b1;
                end else begin
                    wr_input_FIFO_en_o   <= 1'b1;
                    wr_input_FIFO_data_o <= emit_r[63:56];
                    emit_r               <= {emit_r[55:0], 8'd0};
                    emit_cnt_r           <= emit_cnt_r - 4'd1;
                end
            end else begin
                wr_input_FIFO_en_o <= 1'b0;
            end

            // Right slot complete: queue the whole frame or drop it on afull.
            if (done_s && lrck_last_r) begin
                if (wr_input_FIFO_afull_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    emit_r     <= frame_s;
                    emit_cnt_r <= depth_r[5:2];
                end
            end
        end
    end

endmodule

// File: doc/rx_i2s.md
# rx_i2s

I2S receiver for the capture path. It oversamples an external I2S bus (BCLK, LRCK and SDATA driven by the ADC as bus master) in the byte_clk_i domain and deserializes left/right samples of 16, 24 or 32 bits. It then writes whole stereo frames, MSB byte first and left before right, into the write port of the input FIFO that feeds the USB FIFO engine. Its byte order matches the order in which tx_i2s consumes bytes, so a captured stream can be played back unchanged.

## Interface
- No parameters.
- reset_i  in  1  asynchronous, active-high reset.
- byte_clk_i  in  1  clock for all logic. Must be at least 4x the bclk_i frequency.
- enable_i  in  1  capture enable. Level-sensitive.
- bit_depth_i  in  2  `BIT_DEPTH_16 / `BIT_DEPTH_24 / `BIT_DEPTH_DOP / `BIT_DEPTH_32 (definitions.svh). DoP is handled as 24-bit.
- bclk_i, lrck_i, sdata_i  in  1 each  asynchronous I2S inputs.
- wr_input_FIFO_afull_i  in  1  FIFO almost-full, already in the byte_clk_i domain.
- wr_input_FIFO_full_i  in  1  FIFO full.
- wr_input_FIFO_en_o  out  1  one-cycle write strobe.
- wr_input_FIFO_data_o  out  8  byte to write.
- input_streaming_o  out  1  high while in the RUN state.
- overrun_o  out  1  sticky flag: a frame was dropped.
- frame_err_o  out  1  sticky flag: a slot was too short.

## Operation
- Synchronization:
  - bclk_i, lrck_i and sdata_i each pass through a 2-FF synchronizer.
  - A bclk rise is detected when the synced value is 1 and its previous value was 0.
  - lrck and sdata are sampled only on detected bclk rises.
- Framing:
  - Standard I2S: lrck=0 is left, lrck=1 is right.
  - The MSB arrives on the bclk rise after the rise on which an lrck change is seen.
  - bit_idx (5 bits) is set to 0 on an lrck-change rise and increments on every other rise, saturating at 31.
  - Bits with bit_idx 1..N are shifted in MSB first, where N = 16/24/32. Bits beyond N are ignored.
- States:
  - IDLE to SYNC when enable_i=1.
  - SYNC to RUN on the first rise that sees lrck change 1 to 0 (left slot start). N is latched on this transition; bit_depth_i changes are ignored in RUN.
  - RUN to SYNC, setting frame_err_o, when an lrck change arrives with bit_idx < N. The partial frame is discarded.
  - Any state to IDLE when enable_i=0. A frame already being emitted still completes.
- Capture and emission:
  - When bit_idx reaches N in a left slot, the shift register is copied to sample_l.
  - When it reaches N in a right slot, the frame is complete.
  - If wr_input_FIFO_afull_i=1 at frame completion, the frame is dropped and overrun_o is set.
  - Otherwise the block emits 2N/8 bytes (4, 6 or 8) on consecutive byte_clk_i cycles: sample_l MSB to LSB, then sample_r MSB to LSB.
  - If wr_input_FIFO_full_i=1 during emission, the remaining bytes are suppressed and overrun_o is set.
- Sticky flags: overrun_o and frame_err_o clear only on reset_i or on an IDLE to SYNC transition.

## Timing
- Reset values: all outputs 0, state IDLE, bit_idx 0, sample registers 0.
- Latency:
  - Pin to detected bclk rise: 3 byte_clk_i cycles.
  - The first write strobe comes 1 cycle after the detected rise that completes the right sample.
- Emission length: 4/6/8 cycles. This is always shorter than one slot (at least 32 bclk x 4 cycles), so emission never overlaps the next frame's completion.
- Enable timing:
  - enable_i is sampled every cycle.
  - Deasserting it mid-slot discards the partial frame on the next cycle.
  - input_streaming_o falls on the same edge.
- Simultaneous events:
  - A right-sample completion in the same cycle enable_i falls is emitted.
  - afull is checked only on the completion cycle.
- An asynchronous reset mid-emission stops writes immediately. The FIFO may then hold a partial frame; the downstream reader flushes on reset.

## Test plan
- 16-bit, 64fs, L=0xA55A, R=0x1234 -> writes A5,5A,12,34 on 4 consecutive cycles; input_streaming_o=1; no flags set.
- 24-bit L=0x123456, R=0xABCDEF, then DoP with the same data -> each produces 12,34,56,AB,CD,EF.
- 32-bit L=0xDEADBEEF, R=0x01020304 -> 8 bytes DE,AD,BE,EF,01,02,03,04. Enabling mid right slot -> no writes until the first full left+right frame.
- afull=1 at right completion -> no strobes, overrun_o=1. afull=0 on the next frame -> that frame is written normally; overrun_o stays 1 until re-enable.
- 24-bit depth with 16-bit slots (lrck toggles every 16 bclk) -> frame_err_o=1, state returns to SYNC, zero writes.
- reset_i pulse mid-emission of a 32-bit frame -> strobe drops at once; all outputs 0; recapture starts after enable at the next left slot.
